// File: rtl/conv_seq_pkg.sv
// Shared types and constants for the convolution window sequencer.
// Holds the FSM encoding, window count and tap select-code layout.
package conv_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_CAPTURE,
        S_DONE
    } state_t;

    localparam int NUM_WIN = 4;
    localparam logic [1:0] LAST_WIN = 2'(NUM_WIN - 1);

    localparam int MAT_COLS = 4;

    // Select code of matrix element a(row,col), 1-based.
    function automatic logic [3:0] sel_code(input int row, input int col);
        return 4'(MAT_COLS * (row - 1) + (col - 1));
    endfunction

    // Tap offsets relative to the window's top-left element.
    localparam logic [3:0] TAP_11 = sel_code(1, 1);
    localparam logic [3:0] TAP_12 = sel_code(1, 2);
    localparam logic [3:0] TAP_13 = sel_code(1, 3);
    localparam logic [3:0] TAP_21 = sel_code(2, 1);
    localparam logic [3:0] TAP_22 = sel_code(2, 2);
    localparam logic [3:0] TAP_23 = sel_code(2, 3);
    localparam logic [3:0] TAP_31 = sel_code(3, 1);
    localparam logic [3:0] TAP_32 = sel_code(3, 2);
    localparam logic [3:0] TAP_33 = sel_code(3, 3);

endpackage

// File: rtl/conv_window_sequencer_sel_gen.sv
// Combinational select generator: maps window index to the nine
// 4-bit tap select codes of the 3x3 kernel over the 4x4 matrix.
module conv_sel_gen
    import conv_seq_pkg::*;
(
    input  logic [1:0] p,
    output logic [3:0] s11,
    output logic [3:0] s12,
    output logic [3:0] s13,
    output logic [3:0] s21,
    output logic [3:0] s22,
    output logic [3:0] s23,
    output logic [3:0] s31,
    output logic [3:0] s32,
    output logic [3:0] s33
);

    logic [3:0] base;

    // p[1] moves the window down one row, p[0] right one column.
    assign base = {1'b0, p[1], 1'b0, p[0]};

    assign s11 = base + TAP_11;
    assign s12 = base + TAP_12;
    assign s13 = base + TAP_13;
    assign s21 = base + TAP_21;
    assign s22 = base + TAP_22;
    assign s23 = base + TAP_23;
    assign s31 = base + TAP_31;
    assign s32 = base + TAP_32;
    assign s33 = base + TAP_33;

endmodule

// File: rtl/conv_window_sequencer.sv
// Sequences four 3x3 windows over a 4x4 matrix through an external
// convolution datapath and collects the 2x2 result matrix.
module conv_window_sequencer
    import conv_seq_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] conv_out,
    output logic       init,
    output logic [3:0] s0_11,
    output logic [3:0] s0_12,
    output logic [3:0] s0_13,
    output logic [3:0] s0_21,
    output logic [3:0] s0_22,
    output logic [3:0] s0_23,
    output logic [3:0] s0_31,
    output logic [3:0] s0_32,
    output logic [3:0] s0_33,
    output logic [7:0] c11,
    output logic [7:0] c12,
    output logic [7:0] c21,
    output logic [7:0] c22,
    output logic       busy,
    output logic       done
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t     state_q, state_d;
    logic [1:0] p_q, p_d;
    logic [3:0] wait_q, wait_d;
    logic [7:0] c11_q, c11_d;
    logic [7:0] c12_q, c12_d;
    logic [7:0] c21_q, c21_d;
    logic [7:0] c22_q, c22_d;

    logic [3:0] g11, g12, g13;
    logic [3:0] g21, g22, g23;
    logic [3:0] g31, g32, g33;
    logic       sel_on;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            p_q     <= '0;
            wait_q  <= '0;
            c11_q   <= '0;
            c12_q   <= '0;
            c21_q   <= '0;
            c22_q   <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            wait_q  <= wait_d;
            c11_q   <= c11_d;
            c12_q   <= c12_d;
            c21_q   <= c21_d;
            c22_q   <= c22_d;
        end
    end

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        wait_d  = wait_q;
        c11_d   = c11_q;
        c12_d   = c12_q;
        c21_d   = c21_q;
        c22_d   = c22_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    p_d     = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                wait_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wait_q == SETTLE_LAST) begin
                    wait_d  = '0;
                    state_d = S_CAPTURE;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            S_CAPTURE: begin
                unique case (p_q)
                    2'd0: c11_d = conv_out;
                    2'd1: c12_d = conv_out;
                    2'd2: c21_d = conv_out;
                    2'd3: c22_d = conv_out;
                    default: ;
                endcase
                if (p_q == LAST_WIN) begin
                    state_d = S_DONE;
                end else begin
                    p_d     = p_q + 2'd1;
                    state_d = S_LOAD;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    conv_sel_gen u_sel_gen (
        .p   (p_q),
        .s11 (g11),
        .s12 (g12),
        .s13 (g13),
        .s21 (g21),
        .s22 (g22),
        .s23 (g23),
        .s31 (g31),
        .s32 (g32),
        .s33 (g33)
    );

    // Selects are live for the whole window, parked at 0 otherwise.
    assign sel_on = (state_q == S_LOAD) || (state_q == S_WAIT) ||
                    (state_q == S_CAPTURE);

    assign s0_11 = sel_on ? g11 : '0;
    assign s0_12 = sel_on ? g12 : '0;
    assign s0_13 = sel_on ? g13 : '0;
    assign s0_21 = sel_on ? g21 : '0;
    assign s0_22 = sel_on ? g22 : '0;
    assign s0_23 = sel_on ? g23 : '0;
    assign s0_31 = sel_on ? g31 : '0;
    assign s0_32 = sel_on ? g32 : '0;
    assign s0_33 = sel_on ? g33 : '0;

    assign init = (state_q == S_LOAD);
    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);

    assign c11 = c11_q;
    assign c12 = c12_q;
    assign c21 = c21_q;
    assign c22 = c22_q;

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Directed bench: SETTLE=2 instance on a behavioural datapath,
// SETTLE=5 instance on a constant conv_out stub.
module tb_conv_window_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    logic       start_a = 1'b0;
    logic [7:0] conv_a;
    logic       init_a, busy_a, done_a;
    logic [3:0] a11, a12, a13, a21, a22, a23, a31, a32, a33;
    logic [7:0] ca11, ca12, ca21, ca22;

    logic       start_b = 1'b0;
    logic [7:0] conv_b = 8'hA5;
    logic       init_b, busy_b, done_b;
    logic [3:0] b11, b12, b13, b21, b22, b23, b31, b32, b33;
    logic [7:0] cb11, cb12, cb21, cb22;

    conv_window_sequencer #(.SETTLE(2)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .conv_out(conv_a),
        .init(init_a),
        .s0_11(a11), .s0_12(a12), .s0_13(a13),
        .s0_21(a21), .s0_22(a22), .s0_23(a23),
        .s0_31(a31), .s0_32(a32), .s0_33(a33),
        .c11(ca11), .c12(ca12), .c21(ca21), .c22(ca22),
        .busy(busy_a), .done(done_a)
    );

    conv_window_sequencer #(.SETTLE(5)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .conv_out(conv_b),
        .init(init_b),
        .s0_11(b11), .s0_12(b12), .s0_13(b13),
        .s0_21(b21), .s0_22(b22), .s0_23(b23),
        .s0_31(b31), .s0_32(b32), .s0_33(b33),
        .c11(cb11), .c12(cb12), .c21(cb21), .c22(cb22),
        .busy(busy_b), .done(done_b)
    );

    logic [35:0] sel_a;
    logic [35:0] sel_b;
    assign sel_a = {a11, a12, a13, a21, a22, a23, a31, a32, a33};
    assign sel_b = {b11, b12, b13, b21, b22, b23, b31, b32, b33};

    // Datapath with a = 1..16 row-major and all-ones kernel.
    function automatic logic [7:0] dp_sum(input logic [35:0] s);
        logic [7:0] acc;
        acc = '0;
        for (int k = 0; k < 9; k++) acc = acc + 8'(s[k*4 +: 4]) + 8'd1;
        return acc;
    endfunction

    assign conv_a = dp_sum(sel_a);

    function automatic logic [35:0] exp_sel(input logic on, input logic [3:0] b);
        if (!on) return '0;
        return {b, b + 4'd1, b + 4'd2, b + 4'd4, b + 4'd5, b + 4'd6,
                b + 4'd8, b + 4'd9, b + 4'd10};
    endfunction

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int         edge_no;
        logic       init;
        logic       busy;
        logic       done;
        logic       sel_on;
        logic [3:0] base;
    } vec_t;

    vec_t tbl[15];

    function automatic vec_t mk(input int e, input logic i, input logic b,
                                input logic d, input logic on, input logic [3:0] bs);
        vec_t v;
        v.edge_no = e; v.init = i; v.busy = b; v.done = d; v.sel_on = on; v.base = bs;
        return v;
    endfunction

    // Edge 1 is the rising edge that samples start in IDLE.
    task automatic pass_results(input string tag);
        start_a = 1'b1;
        for (int e = 1; e <= 18; e++) begin
            @(posedge clk); #1;
            if (e == 1) start_a = 1'b0;
            if (e == 16) chk({tag, "_done16"}, 80'(done_a), 80'd0);
            if (e == 17) chk({tag, "_done17"}, 80'(done_a), 80'd1);
            if (e == 18) chk({tag, "_c"}, 80'({ca11, ca12, ca21, ca22}),
                             80'({8'd54, 8'd63, 8'd90, 8'd99}));
        end
    endtask

    initial begin
        int cur;
        int starts[$];

        tbl[0]  = mk(1,  1, 1, 0, 1, 4'd0);
        tbl[1]  = mk(2,  0, 1, 0, 1, 4'd0);
        tbl[2]  = mk(3,  0, 1, 0, 1, 4'd0);
        tbl[3]  = mk(4,  0, 1, 0, 1, 4'd0);
        tbl[4]  = mk(5,  1, 1, 0, 1, 4'd1);
        tbl[5]  = mk(6,  0, 1, 0, 1, 4'd1);
        tbl[6]  = mk(8,  0, 1, 0, 1, 4'd1);
        tbl[7]  = mk(9,  1, 1, 0, 1, 4'd4);
        tbl[8]  = mk(11, 0, 1, 0, 1, 4'd4);
        tbl[9]  = mk(12, 0, 1, 0, 1, 4'd4);
        tbl[10] = mk(13, 1, 1, 0, 1, 4'd5);
        tbl[11] = mk(14, 0, 1, 0, 1, 4'd5);
        tbl[12] = mk(16, 0, 1, 0, 1, 4'd5);
        tbl[13] = mk(17, 0, 1, 1, 0, 4'd0);
        tbl[14] = mk(18, 0, 0, 0, 0, 4'd0);

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctrl", 80'({init_a, busy_a, done_a, sel_a}), 80'd0);
        chk("rst_c", 80'({ca11, ca12, ca21, ca22}), 80'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_busy", 80'(busy_a), 80'd0);

        // Pass 1: table walk, stray start mid-pass and during DONE.
        start_a = 1'b1;
        cur = 0;
        for (int i = 0; i < 15; i++) begin
            while (cur < tbl[i].edge_no) begin
                @(posedge clk); #1;
                cur++;
                case (cur)
                    1: start_a = 1'b0;
                    6: start_a = 1'b1;
                    7: start_a = 1'b0;
                    17: start_a = 1'b1;
                    18: start_a = 1'b0;
                    default: ;
                endcase
            end
            chk($sformatf("e%0d_ctrl", cur), 80'({init_a, busy_a, done_a}),
                80'({tbl[i].init, tbl[i].busy, tbl[i].done}));
            chk($sformatf("e%0d_sel", cur), 80'(sel_a),
                80'(exp_sel(tbl[i].sel_on, tbl[i].base)));
        end
        chk("p1_c", 80'({ca11, ca12, ca21, ca22}),
            80'({8'd54, 8'd63, 8'd90, 8'd99}));

        // Pass 2: start held high, passes every 18 cycles.
        start_a = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            if (init_a && sel_a == exp_sel(1'b1, 4'd0)) starts.push_back(n);
        end
        start_a = 1'b0;
        chk("cont_starts", 80'(starts.size()), 80'd4);
        if (starts.size() >= 3) begin
            chk("cont_first", 80'(starts[0]), 80'd1);
            chk("cont_gap1", 80'(starts[1] - starts[0]), 80'd18);
            chk("cont_gap2", 80'(starts[2] - starts[1]), 80'd18);
        end
        repeat (20) @(posedge clk);
        #1;
        chk("cont_idle", 80'(busy_a), 80'd0);
        chk("cont_c", 80'({ca11, ca12, ca21, ca22}),
            80'({8'd54, 8'd63, 8'd90, 8'd99}));

        // Pass 3: async reset in WAIT of window 2.
        start_a = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk); #1;
            if (e == 1) start_a = 1'b0;
        end
        chk("w2_sel", 80'({init_a, sel_a}), 80'({1'b0, exp_sel(1'b1, 4'd4)}));
        rst = 1'b1;
        #1;
        chk("arst_ctrl", 80'({init_a, busy_a, done_a, sel_a}), 80'd0);
        chk("arst_c", 80'({ca11, ca12, ca21, ca22}), 80'd0);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("arst_idle", 80'(busy_a), 80'd0);
        pass_results("post_rst");

        // Pass 4: SETTLE=5 with a constant datapath.
        start_b = 1'b1;
        for (int e = 1; e <= 30; e++) begin
            @(posedge clk); #1;
            if (e == 1) start_b = 1'b0;
            if (e == 28) chk("s5_done28", 80'(done_b), 80'd0);
            if (e == 29) chk("s5_done29", 80'(done_b), 80'd1);
            if (e == 30) begin
                chk("s5_done30", 80'({busy_b, done_b}), 80'd0);
                chk("s5_c", 80'({cb11, cb12, cb21, cb22}), 80'h00000000_00A5A5A5A5);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
